ifetch_align_q: RTL and testbench

- Parametrised instruction-fetch aligner for the barrel-threaded core, sitting between the per-hart PC scheduler and the synchronous instruction BRAM.
- Issues fetches and carries each request's {hart, pc} through a tag pipeline matched to the BRAM read latency.
- Pairs returned rdata with its exact pc/hart, so pc/inst misalignment cannot occur.
- Buffers results in a credit-managed queue and squashes per-hart fetches on redirect. Successor to the fixed 2-hart, 1-cycle-latency IF stage.

---
 rtl/ifetch_align_if.sv | 35 +++
 rtl/ifetch_align_q.sv | 147 ++++++++++++++
 tb/tb_ifetch_align_q.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_align_if.sv
// Fetch aligner signal bundle: scheduler request, BRAM port, flush and decode side.
// slave = the aligner, master = the logic around it.
interface ifetch_align_if #(
    parameter int HW   = 1,
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [HW-1:0]   req_hart;
    logic [XLEN-1:0] req_pc;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic            flush_valid;
    logic [HW-1:0]   flush_hart;
    logic            if_valid;
    logic            if_ready;
    logic [HW-1:0]   if_hart;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_inst;

    modport slave (
        input  req_valid, req_hart, req_pc, mem_rdata,
        input  flush_valid, flush_hart, if_ready,
        output req_ready, mem_req, mem_addr,
        output if_valid, if_hart, if_pc, if_inst
    );

    modport master (
        output req_valid, req_hart, req_pc, mem_rdata,
        output flush_valid, flush_hart, if_ready,
        input  req_ready, mem_req, mem_addr,
        input  if_valid, if_hart, if_pc, if_inst
    );
endinterface

// File: rtl/ifetch_align_q.sv
// ifetch_align_q: pairs BRAM read data with its {hart, pc} tag and queues results.
// Optional fetch/squash counters are built when IFETCH_ALIGN_STATS_EN is defined.
module ifetch_align_q #(
    parameter int NUM_HARTS   = 2,
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1,
    parameter int OUT_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    ifetch_align_if.slave bus
`ifdef IFETCH_ALIGN_STATS_EN
    ,
    output logic [31:0] stat_fetch,
    output logic [31:0] stat_squash
`endif
);
    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + MEM_LATENCY + 1);

    typedef struct packed {
        logic [HW-1:0]   hart;
        logic [XLEN-1:0] pc;
    } tag_t;

    logic [MEM_LATENCY-1:0] tv;
    tag_t                   tg [MEM_LATENCY];

    logic [OUT_DEPTH-1:0]   qkill;
    logic [HW-1:0]          qhart [OUT_DEPTH];
    logic [XLEN-1:0]        qpc   [OUT_DEPTH];
    logic [XLEN-1:0]        qinst [OUT_DEPTH];
    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [PW:0]            count;

    logic [CW-1:0]          live;
    logic [CW-1:0]          outstanding;
    logic                   issue;
    logic                   push;
    logic                   push_kill;
    logic                   nonempty;
    logic                   head_kill;
    logic                   pop;

    always_comb begin
        live = '0;
        for (int i = 0; i < MEM_LATENCY; i++) live = live + CW'(tv[i]);
    end

    // Credits cover every fetch not yet popped, so the queue can never overflow.
    assign outstanding   = live + CW'(count);
    assign bus.req_ready = rst_n && (outstanding < CW'(OUT_DEPTH));
    assign issue         = bus.req_valid && bus.req_ready;
    assign bus.mem_req   = issue;
    assign bus.mem_addr  = issue ? bus.req_pc : '0;

    assign push      = tv[MEM_LATENCY-1];
    assign push_kill = bus.flush_valid &&
                       (tg[MEM_LATENCY-1].hart == bus.flush_hart);

    assign nonempty     = (count != '0);
    assign head_kill    = qkill[rd_ptr];
    assign bus.if_valid = nonempty && !head_kill;
    assign pop          = nonempty && (head_kill || bus.if_ready);
    assign bus.if_hart  = qhart[rd_ptr];
    assign bus.if_pc    = qpc[rd_ptr];
    assign bus.if_inst  = qinst[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tv <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) tg[i] <= '0;
        end else begin
            tv[0] <= issue;
            if (issue) tg[0] <= '{hart: bus.req_hart, pc: bus.req_pc};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tv[i] <= tv[i-1] &&
                         !(bus.flush_valid && tg[i-1].hart == bus.flush_hart);
                tg[i] <= tg[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qkill  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                qhart[i] <= '0;
                qpc[i]   <= '0;
                qinst[i] <= '0;
            end
        end else begin
            // Stale free slots may get kill set too; a push overwrites it.
            for (int i = 0; i < OUT_DEPTH; i++)
                if (bus.flush_valid && qhart[i] == bus.flush_hart)
                    qkill[i] <= 1'b1;
            if (push) begin
                qkill[wr_ptr] <= push_kill;
                qhart[wr_ptr] <= tg[MEM_LATENCY-1].hart;
                qpc[wr_ptr]   <= tg[MEM_LATENCY-1].pc;
                qinst[wr_ptr] <= bus.mem_rdata;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count == (PW+1)'(OUT_DEPTH)));

`ifdef IFETCH_ALIGN_STATS_EN
    logic [CW-1:0] nkill;
    logic [32:0]   sq_sum;

    always_comb begin
        nkill = '0;
        if (bus.flush_valid) begin
            for (int i = 0; i < MEM_LATENCY; i++)
                if (tv[i] && tg[i].hart == bus.flush_hart)
                    nkill = nkill + CW'(1);
            for (int i = 0; i < OUT_DEPTH; i++)
                if (((PW+1)'(PW'(PW'(i) - rd_ptr)) < count) && !qkill[i] &&
                    qhart[i] == bus.flush_hart &&
                    !(pop && PW'(i) == rd_ptr))
                    nkill = nkill + CW'(1);
        end
    end

    assign sq_sum = {1'b0, stat_squash} + 33'(nkill);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetch  <= '0;
            stat_squash <= '0;
        end else begin
            if (issue && stat_fetch != '1) stat_fetch <= stat_fetch + 32'd1;
            stat_squash <= sq_sum[32] ? '1 : sq_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_ifetch_align_q.sv
// Bench for ifetch_align_q: vector table, directed corner cases, random vs queue model.
// Builds with or without IFETCH_ALIGN_STATS_EN.
module tb_ifetch_align_q;
    localparam int NH  = 2;
    localparam int XL  = 32;
    localparam int LAT = 3;
    localparam int DEP = 4;
    localparam int HW  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ifetch_align_if #(.HW(HW), .XLEN(XL)) bus ();

`ifdef IFETCH_ALIGN_STATS_EN
    logic [31:0] stat_fetch;
    logic [31:0] stat_squash;
`endif

    ifetch_align_q #(
        .NUM_HARTS(NH), .XLEN(XL), .MEM_LATENCY(LAT), .OUT_DEPTH(DEP)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef IFETCH_ALIGN_STATS_EN
        ,
        .stat_fetch(stat_fetch),
        .stat_squash(stat_squash)
`endif
    );

    // BRAM contents: hart0 region addi x0,x0,w+1; hart1 region branch words.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        logic [31:0] w;
        w = a >> 2;
        if (a < 32'h200) return ((w + 32'd1) << 20) | 32'h13;
        return ((w - 32'h80) << 20) | 32'h63;
    endfunction

    logic [31:0] mpipe [LAT];
    always @(posedge clk) begin
        mpipe[0] <= bus.mem_addr;
        for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
    assign bus.mem_rdata = memfn(mpipe[LAT-1]);

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.req_valid   = 1'b0;
        bus.req_hart    = '0;
        bus.req_pc      = '0;
        bus.flush_valid = 1'b0;
        bus.flush_hart  = '0;
        bus.if_ready    = 1'b0;
    endtask

    task automatic issue_n(input int n, input logic [HW-1:0] h,
                           input logic [31:0] base);
        int k = 0;
        int t = 0;
        while (k < n && t < 50) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            bus.req_hart  = h;
            bus.req_pc    = base + 32'(4 * k);
            @(negedge clk);
            if (bus.req_ready) k++;
            t++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("issue_n_count", 64'(k), 64'(n));
    endtask

    typedef struct {
        logic        rv;
        logic [31:0] pc;
        logic        rdy;
        logic        e_rr;
        logic        e_mreq;
        logic        e_iv;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    typedef struct {
        logic [HW-1:0] h;
        logic [31:0]   pc;
    } ent_t;

    ent_t        model[$];
    logic [HW-1:0] nh = '0;
    logic [31:0] pc0 = 32'h0;
    logic [31:0] pc1 = 32'h200;

    task automatic rnd_cycle(input bit active);
        ent_t keep[$];
        @(posedge clk); #1;
        bus.req_valid   = active && ($urandom_range(0, 3) != 0);
        bus.req_hart    = nh;
        bus.req_pc      = (nh != '0) ? pc1 : pc0;
        bus.flush_valid = active && ($urandom_range(0, 15) == 0);
        bus.flush_hart  = HW'($urandom_range(0, 1));
        bus.if_ready    = !active || ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bus.if_valid) begin
            if (model.size() == 0) begin
                check("rnd_spurious", 64'(bus.if_pc), 64'hdead);
            end else begin
                check("rnd_hart_pc", {bus.if_hart, bus.if_pc},
                      {model[0].h, model[0].pc});
                check("rnd_inst", bus.if_inst, memfn(model[0].pc));
                if (bus.if_ready) void'(model.pop_front());
            end
        end
        if (bus.flush_valid) begin
            foreach (model[i])
                if (model[i].h != bus.flush_hart) keep.push_back(model[i]);
            model = keep;
        end
        if (bus.req_valid && bus.req_ready) begin
            model.push_back('{h: bus.req_hart, pc: bus.req_pc});
            if (nh != '0) pc1 = 32'h200 | ((pc1 + 32'd4) & 32'h1ff);
            else pc0 = (pc0 + 32'd4) & 32'h1ff;
            nh = ~nh;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tab[10];
        logic [31:0] ki[3];
        ent_t        got[$];
        int          acc;

        ki[0] = 32'h00100013;
        ki[1] = 32'h00200013;
        ki[2] = 32'h00300013;
        for (int c = 0; c < 10; c++) begin
            tab[c].rv     = (c < 3);
            tab[c].pc     = 32'(4 * c);
            tab[c].rdy    = 1'b1;
            tab[c].e_rr   = 1'b1;
            tab[c].e_mreq = (c < 3);
            tab[c].e_iv   = (c >= LAT + 1) && (c <= LAT + 3);
            tab[c].e_pc   = 32'(4 * (c - LAT - 1));
            tab[c].e_inst = tab[c].e_iv ? ki[c - LAT - 1] : 32'h0;
        end

        // Reset state, with a request held to show it is not accepted.
        idle();
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h1234;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_mem_req", 64'(bus.mem_req), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_if_valid", 64'(bus.if_valid), 64'd0);
        check("rst_if_fields", {bus.if_hart, bus.if_pc, bus.if_inst}, 64'd0);
        idle();
        rst_n = 1'b1;

        // Back-to-back hart0 fetches, consumer always ready.
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.req_valid = tab[c].rv;
            bus.req_hart  = '0;
            bus.req_pc    = tab[c].pc;
            bus.if_ready  = tab[c].rdy;
            @(negedge clk);
            check($sformatf("tab%0d_req_ready", c), 64'(bus.req_ready),
                  64'(tab[c].e_rr));
            check($sformatf("tab%0d_mem_req", c), 64'(bus.mem_req),
                  64'(tab[c].e_mreq));
            if (tab[c].e_mreq)
                check($sformatf("tab%0d_mem_addr", c), 64'(bus.mem_addr),
                      64'(tab[c].pc));
            check($sformatf("tab%0d_if_valid", c), 64'(bus.if_valid),
                  64'(tab[c].e_iv));
            if (tab[c].e_iv)
                check($sformatf("tab%0d_out", c),
                      {bus.if_hart, bus.if_pc, bus.if_inst},
                      {1'b0, tab[c].e_pc, tab[c].e_inst});
        end

        // Credit limit with a stalled consumer, then drain.
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b1;
            bus.req_hart  = '0;
            bus.req_pc    = 32'h20 + 32'(4 * acc);
            bus.if_ready  = 1'b0;
            @(negedge clk);
            if (bus.req_ready) acc++;
        end
        check("credit_accepted", 64'(acc), 64'(DEP));
        check("credit_ready_low", 64'(bus.req_ready), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            bus.if_ready  = 1'b1;
            @(negedge clk);
            check($sformatf("drain%0d_valid", k), 64'(bus.if_valid), 64'd1);
            check($sformatf("drain%0d_pc", k), 64'(bus.if_pc),
                  64'(32'h20 + 32'(4 * k)));
            check($sformatf("drain%0d_inst", k), 64'(bus.if_inst),
                  64'(memfn(32'h20 + 32'(4 * k))));
            check($sformatf("drain%0d_req_ready", k), 64'(bus.req_ready),
                  64'(k != 0));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("drain_empty", 64'(bus.if_valid), 64'd0);

        // Flush hart0 with two hart0 and one hart1 fetch in flight.
        idle();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            bus.req_valid   = 1'b1;
            bus.req_hart    = (c == 2) ? 1'b1 : 1'b0;
            bus.req_pc      = (c == 0) ? 32'h100 : (c == 1) ? 32'h104 :
                              (c == 2) ? 32'h200 : 32'h40;
            bus.flush_valid = (c == 3);
            bus.flush_hart  = '0;
            @(negedge clk);
            check($sformatf("flush_req%0d_ready", c), 64'(bus.req_ready), 64'd1);
        end
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            idle();
            bus.if_ready = 1'b1;
            @(negedge clk);
            if (bus.if_valid) got.push_back('{h: bus.if_hart, pc: bus.if_pc});
            if (bus.if_valid)
                check("flush_inst", 64'(bus.if_inst), 64'(memfn(bus.if_pc)));
        end
        check("flush_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            check("flush_first", {got[0].h, got[0].pc}, {1'b1, 32'h200});
            check("flush_second", {got[1].h, got[1].pc}, {1'b0, 32'h40});
        end
        check("flush_h1_inst", 64'(memfn(32'h200)), 64'h63);

        // Reset while three fetches are in flight.
        idle();
        issue_n(3, 1'b0, 32'h80);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", 64'(bus.req_ready), 64'd0);
        check("midrst_if_valid", 64'(bus.if_valid), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 64'(bus.req_ready), 64'd1);
        check("post_rst_valid", 64'(bus.if_valid), 64'd0);
        bus.if_ready = 1'b1;
        for (int c = 0; c < LAT + 3; c++) begin
            @(negedge clk);
            check($sformatf("post_rst_valid%0d", c), 64'(bus.if_valid), 64'd0);
        end

`ifdef IFETCH_ALIGN_STATS_EN
        check("stat_fetch_rst", 64'(stat_fetch), 64'd0);
        bus.if_ready = 1'b1;
        issue_n(7, 1'b1, 32'h200);
        repeat (10) @(posedge clk);
        #1;
        bus.if_ready = 1'b0;
        issue_n(3, 1'b0, 32'h0);
        bus.flush_valid = 1'b1;
        bus.flush_hart  = '0;
        @(posedge clk); #1;
        bus.flush_valid = 1'b0;
        @(negedge clk);
        check("stat_fetch", 64'(stat_fetch), 64'd10);
        check("stat_squash", 64'(stat_squash), 64'd3);
        bus.if_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("stat_killed_hidden%0d", c), 64'(bus.if_valid), 64'd0);
        end
`endif

        // Random traffic against the issue-order queue model.
        idle();
        model.delete();
        repeat (2) @(posedge clk);
        for (int c = 0; c < 400; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 20; c++) rnd_cycle(1'b0);
        check("rnd_drained", 64'(model.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
